// File: rtl/div36x18_seq.sv
// Sequential unsigned radix-2 restoring divider (DW-bit dividend / VW-bit divisor).
// Produces one quotient bit per enabled clock. Operands enter through a
// valid/ready handshake and results leave through another. A clock enable
// freezes the whole block, so it can sit in the same stalled pipelines as the
// 18x18 multiplier.
//
// Handshake contract (both sides): a transfer happens on an enabled rising
// edge where valid and ready are both high. in_ready is high only while IDLE.
// out_valid is high only while DONE. Once asserted, out_valid and the result
// stay put until the consumer takes them.
module div36x18_seq #(
  parameter int DW = 36,
  parameter int VW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [DW-1:0] shq_q;      // dividend in, quotient bits shifted in from the right
  logic [VW-1:0] rem_q;      // partial remainder, always < divisor so VW bits suffice
  logic [VW-1:0] dvs_q;      // latched divisor
  logic [CW-1:0] cnt_q;      // iterations still to do
  logic [DW-1:0] quo_q;      // published quotient
  logic [VW-1:0] rmd_q;      // published remainder
  logic          dbz_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [VW:0]   trial;
  logic          fits;
  logic [VW-1:0] rem_d;
  logic [DW-1:0] shq_d;

  // One restoring step: the trial value is VW+1 bits wide, so it never overflows.
  // The subtraction is done in VW bits because a fitting difference is always < divisor.
  always_comb begin
    trial = {rem_q, shq_q[DW-1]};
    fits  = (trial >= {1'b0, dvs_q});
    rem_d = fits ? (trial[VW-1:0] - dvs_q) : trial[VW-1:0];
    shq_d = {shq_q[DW-2:0], fits};
  end

  // Control FSM and all datapath registers. Everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shq_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (divisor != '0) begin
              shq_q   <= dividend;
              rem_q   <= '0;
              dvs_q   <= divisor;
              cnt_q   <= CW'(DW);
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end else begin
              // A zero divisor skips the iterations: saturated quotient, low dividend bits as remainder.
              quo_q       <= '1;
              rmd_q       <= dividend[VW-1:0];
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          shq_q <= shq_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            quo_q       <= shq_d;
            rmd_q       <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Hand-off edge; in_ready rises only afterwards, so no accept can share this edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div36x18_seq.sv
// Self-checking bench for div36x18_seq: directed corner cases, randomized
// operands against an arithmetic reference model, backpressure, enable stall,
// reset mid-operation and back-to-back throughput.
module tb_div36x18_seq;

  localparam int DW = 36;
  localparam int VW = 18;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  div36x18_seq #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division with the zero-divisor rule.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
    logic [DW-1:0] rw;
    if (b == '0) begin
      q = '1;
      r = a[VW-1:0];
      z = 1'b1;
    end else begin
      q  = a / DW'(b);
      rw = a % DW'(b);
      r  = rw[VW-1:0];
      z  = 1'b0;
    end
  endtask

  // Present operands for one accepting edge (caller ensures in_ready is high).
  task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_result(inout int lat);
    while (out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Full operation with out_ready high; returns latency and the result seen in DONE.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat,
                        output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
    out_ready = 1'b1;
    start_op(a, b);
    lat = 0;
    wait_result(lat);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    tick(); tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    n_tests++;
    if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got q=%h r=%h z=%b, required 0 0 0", quotient, remainder, div_by_zero);
    end
    #2 rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b state=%0d, required 1 0 0",
               in_ready, out_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    int lat; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got in_ready=%b, required 1", in_ready);
    end
    run_op(36'd100, 18'd7, lat, q, r, z);
    n_tests++;
    if (lat !== DW) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, DW);
    end
    n_tests++;
    if (q !== 36'd14 || r !== 18'd2 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b, required 14 2 0", q, r, z);
    end
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_handoff: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    logic [DW-1:0] ea [3] = '{36'hF_FFFF_FFFF, 36'h1_2345_6789, 36'd5};
    logic [VW-1:0] eb [3] = '{18'h3FFFF, 18'd1, 18'h3FFFF};
    logic [DW-1:0] eq [3] = '{36'h4_0001, 36'h1_2345_6789, 36'd0};
    logic [VW-1:0] er [3] = '{18'd0, 18'd0, 18'd5};
    int lat; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    for (int i = 0; i < 3; i++) begin
      run_op(ea[i], eb[i], lat, q, r, z);
      n_tests++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat !== DW) begin
        n_fail++;
        $display("FAIL extreme_%0d: got q=%h r=%h z=%b lat=%0d, required q=%h r=%h z=0 lat=%0d",
                 i, q, r, z, lat, eq[i], er[i], DW);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    run_op(36'h4D2, 18'd0, lat, q, r, z);
    // Result is visible right after the accepting edge itself.
    n_tests++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL dbz_latency: got %0d edges after accept, required 0", lat);
    end
    n_tests++;
    if (q !== 36'hF_FFFF_FFFF || r !== 18'h4D2 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%h r=%h z=%b, required fffffffff 004d2 1", q, r, z);
    end
    run_op(36'd9, 18'd3, lat, q, r, z);
    n_tests++;
    if (q !== 36'd3 || r !== 18'd0 || z !== 1'b0 || lat !== DW) begin
      n_fail++;
      $display("FAIL dbz_clear: got q=%0d r=%0d z=%b lat=%0d, required 3 0 0 %0d", q, r, z, lat, DW);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, eqv; logic [VW-1:0] b, erv; logic ez;
    int lat; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    int sel;
    for (int i = 0; i < 24; i++) begin
      a   = {4'($urandom), 32'($urandom)};
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel <= 2) b = 18'($urandom_range(1, 15));
      else               b = 18'($urandom);
      model(a, b, eqv, erv, ez);
      run_op(a, b, lat, q, r, z);
      n_tests++;
      if (q !== eqv || r !== erv || z !== ez || lat !== (ez ? 0 : DW)) begin
        n_fail++;
        $display("FAIL random_%0d %h/%h: got q=%h r=%h z=%b lat=%0d, required q=%h r=%h z=%b lat=%0d",
                 i, a, b, q, r, z, lat, eqv, erv, ez, ez ? 0 : DW);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a1, a2, q1, q2; logic [VW-1:0] b1, b2, r1, r2; logic z1, z2;
    int lat; int bad;
    a1 = {4'($urandom), 32'($urandom)}; b1 = 18'($urandom_range(1, 262143));
    a2 = {4'($urandom), 32'($urandom)}; b2 = 18'($urandom_range(1, 1000));
    model(a1, b1, q1, r1, z1);
    model(a2, b2, q2, r2, z2);
    out_ready = 1'b0;
    start_op(a1, b1);
    lat = 0;
    wait_result(lat);
    n_tests++;
    if (lat !== DW) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d, required %0d", lat, DW);
    end
    in_valid = 1'b1; dividend = a2; divisor = b2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q1 || remainder !== r1 || div_by_zero !== z1)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles (last q=%h r=%h v=%b rdy=%b), required 0 with q=%h r=%h",
               bad, quotient, remainder, out_valid, in_ready, q1, r1);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_bubble: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got in_ready=%b after accept edge, required 0", in_ready);
    end
    lat = 0;
    wait_result(lat);
    n_tests++;
    if (quotient !== q2 || remainder !== r2 || div_by_zero !== z2 || lat !== DW) begin
      n_fail++;
      $display("FAIL bp_second: got q=%h r=%h z=%b lat=%0d, required q=%h r=%h z=%b lat=%0d",
               quotient, remainder, div_by_zero, lat, q2, r2, z2, DW);
    end
    tick();
  endtask

  task automatic test_enable_stall();
    int lat; int bad; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    run_op(36'd9, 18'd3, lat, q, r, z);
    start_op(36'd100, 18'd7);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
    end
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lat++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== 36'd3 || remainder !== 18'd0)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_frozen: %0d cycles changed (v=%b rdy=%b q=%0d), required frozen at 0 0 3",
               bad, out_valid, in_ready, quotient);
    end
    en = 1'b1;
    wait_result(lat);
    n_tests++;
    if (lat !== DW + 5 || quotient !== 36'd14 || remainder !== 18'd2) begin
      n_fail++;
      $display("FAIL stall_result: got lat=%0d q=%0d r=%0d, required lat=%0d q=14 r=2",
               lat, quotient, remainder, DW + 5);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int lat; logic [DW-1:0] q; logic [VW-1:0] r; logic z;
    start_op(36'd123456, 18'd77);
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got v=%b rdy=%b q=%h z=%b, required 0 1 0 0",
               out_valid, in_ready, quotient, div_by_zero);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_op(36'd1000, 18'd10, lat, q, r, z);
    n_tests++;
    if (q !== 36'd100 || r !== 18'd0 || z !== 1'b0 || lat !== DW) begin
      n_fail++;
      $display("FAIL midop_after: got q=%0d r=%0d z=%b lat=%0d, required 100 0 0 %0d", q, r, z, lat, DW);
    end
  endtask

  task automatic test_back_to_back();
    int gap; int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1; dividend = 36'd50; divisor = 18'd5;
    tick();
    gap = 0;
    while (in_ready !== 1'b1 && gap < 200) begin
      tick();
      gap++;
    end
    // in_ready returns DW+1 edges after an accept; the next accept is one edge later.
    n_tests++;
    if (gap !== DW + 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got in_ready back %0d edges after accept, required %0d", gap, DW + 1);
    end
    dividend = 36'd77; divisor = 18'd8;
    tick();
    in_valid = 1'b0;
    lat = 0;
    wait_result(lat);
    n_tests++;
    if (quotient !== 36'd9 || remainder !== 18'd5 || lat !== DW) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, required 9 5 %0d", quotient, remainder, lat, DW);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_random();
    test_backpressure();
    test_enable_stall();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
